// File: rtl/pipe_ctrl_if.sv
// Bundle of stall, exception and status signals between the pipeline and pipe_ctrl.
// The master side belongs to the pipeline stages; pipe_ctrl connects to the slave side.
interface pipe_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        clr_timeout;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i, clr_timeout,
    input  stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i, clr_timeout,
    output stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control for the six-stage core: stall merging, exception flush/redirect with a
// one-cycle double-flush guard, stall watchdog and performance counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN, GUARD} state_t;

  localparam logic [31:0] EXC_ERET  = 32'h0000_000e;
  localparam logic [15:0] RUN_LIMIT = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_exc_acc;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic        w_stalled;
  logic        w_wd_hit;

  logic [15:0] r_run_cnt;
  logic        r_stall_timeout;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  // Outputs are gated by rst so they read 0 the instant reset asserts, not at the next edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_next_state = RUN;
    w_exc_acc    = 1'b0;
    w_stall      = 6'b000000;
    w_flush      = 1'b0;
    w_new_pc     = '0;
    if (rst) begin
      w_exc_acc = (r_state == RUN) && (bus.excepttype_i != '0);
      if (w_exc_acc) begin
        w_flush      = 1'b1;
        w_new_pc     = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
        w_next_state = GUARD;
      end else if (bus.stallreq_from_mem) begin
        w_stall = 6'b011111;
      end else if (bus.stallreq_from_ex) begin
        w_stall = 6'b001111;
      end else if (bus.stallreq_from_id || bus.stallreq_from_if) begin
        w_stall = 6'b000111;
      end
    end
  end

  assign w_stalled = (w_stall != 6'b000000);
  assign w_wd_hit  = w_stalled && (r_run_cnt == RUN_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Watchdog run length saturates rather than wrapping so a very long stall cannot re-arm it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_cnt       <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      if (!w_stalled) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != 16'hFFFF) begin
        r_run_cnt <= r_run_cnt + 16'd1;
      end
      r_stall_timeout <= w_wd_hit | (r_stall_timeout & ~bus.clr_timeout);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stalled) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign bus.stall         = w_stall;
  assign bus.flush         = w_flush;
  assign bus.new_pc        = w_new_pc;
  assign bus.stall_timeout = r_stall_timeout;
  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.flush_count   = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table plus hand sequences for reset, watchdog and wrap.
module tb_pipe_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // req is {mem, ex, id, if}
  typedef struct {
    logic [3:0]  req;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
  } vec_t;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[15];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] m_stall_cycles;
  logic [15:0] m_flush_count;
  int          m_run;
  logic        m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_stall_cycles = '0;
    m_flush_count  = '0;
    m_run          = 0;
    m_to           = 1'b0;
  endtask

  // Called at a falling edge: drive one cycle, compare mid-low-phase, then advance to next falling edge.
  task automatic cycle(input string tag, input logic [3:0] req, input logic [31:0] exc,
                       input logic [31:0] epc, input logic clr, input logic [5:0] e_stall,
                       input logic e_flush, input logic [31:0] e_pc);
    exp_t e;
    logic set;
    {bus.stallreq_from_mem, bus.stallreq_from_ex, bus.stallreq_from_id, bus.stallreq_from_if} = req;
    bus.excepttype_i = exc;
    bus.cp0_epc_i    = epc;
    bus.clr_timeout  = clr;
    sb.push_back('{e_stall, e_flush, e_pc});
    #2;
    e = sb.pop_front();
    check({tag, " stall"},         32'(bus.stall),         32'(e.stall));
    check({tag, " flush"},         32'(bus.flush),         32'(e.flush));
    check({tag, " new_pc"},        bus.new_pc,             e.new_pc);
    check({tag, " stall_cycles"},  bus.stall_cycles,       m_stall_cycles);
    check({tag, " flush_count"},   32'(bus.flush_count),   32'(m_flush_count));
    check({tag, " stall_timeout"}, 32'(bus.stall_timeout), 32'(m_to));
    set = 1'b0;
    if (e_stall != 6'b000000) begin
      m_stall_cycles = m_stall_cycles + 32'd1;
      set = (m_run == TB_TIMEOUT - 1);
      if (m_run < 65535) m_run++;
    end else begin
      m_run = 0;
    end
    m_to = set | (m_to & ~clr);
    if (e_flush) m_flush_count = m_flush_count + 16'd1;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0]  = '{4'b0000, 32'h0, 32'h0,         6'b000000, 1'b0, 32'h0};
    vecs[1]  = '{4'b0001, 32'h0, 32'h0,         6'b000111, 1'b0, 32'h0};
    vecs[2]  = '{4'b0010, 32'h0, 32'h0,         6'b000111, 1'b0, 32'h0};
    vecs[3]  = '{4'b0100, 32'h0, 32'h0,         6'b001111, 1'b0, 32'h0};
    vecs[4]  = '{4'b0111, 32'h0, 32'h0,         6'b001111, 1'b0, 32'h0};
    vecs[5]  = '{4'b1111, 32'h0, 32'h0,         6'b011111, 1'b0, 32'h0};
    vecs[6]  = '{4'b0000, 32'h0, 32'h0,         6'b000000, 1'b0, 32'h0};
    vecs[7]  = '{4'b1000, 32'h8, 32'h0,         6'b000000, 1'b1, 32'h20};
    vecs[8]  = '{4'b1000, 32'h8, 32'h0,         6'b011111, 1'b0, 32'h0};
    vecs[9]  = '{4'b0100, 32'h8, 32'h0,         6'b000000, 1'b1, 32'h20};
    vecs[10] = '{4'b0100, 32'h8, 32'h0,         6'b001111, 1'b0, 32'h0};
    vecs[11] = '{4'b0000, 32'he, 32'h8000_1234, 6'b000000, 1'b1, 32'h8000_1234};
    vecs[12] = '{4'b0000, 32'h0, 32'h0,         6'b000000, 1'b0, 32'h0};
    vecs[13] = '{4'b0000, 32'h8, 32'h0,         6'b000000, 1'b1, 32'h20};
    vecs[14] = '{4'b0000, 32'h0, 32'h0,         6'b000000, 1'b0, 32'h0};

    rst = 1'b0;
    {bus.stallreq_from_mem, bus.stallreq_from_ex, bus.stallreq_from_id, bus.stallreq_from_if} = 4'b0000;
    bus.excepttype_i = '0;
    bus.cp0_epc_i    = '0;
    bus.clr_timeout  = 1'b0;
    model_reset();

    @(negedge clk);
    check("reset stall",         32'(bus.stall),         32'h0);
    check("reset flush",         32'(bus.flush),         32'h0);
    check("reset new_pc",        bus.new_pc,             32'h0);
    check("reset stall_cycles",  bus.stall_cycles,       32'h0);
    check("reset flush_count",   32'(bus.flush_count),   32'h0);
    check("reset stall_timeout", 32'(bus.stall_timeout), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].req, vecs[i].exc, vecs[i].epc, 1'b0,
            vecs[i].stall, vecs[i].flush, vecs[i].new_pc);
    end
    check("table flush_count", 32'(bus.flush_count), 32'd4);

    // Clear the flag left by the long stall in the table.
    cycle("clr1", 4'b0000, 32'h0, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
    check("clr1 flag", 32'(bus.stall_timeout), 32'h0);

    // Watchdog: three stalled edges stay below TIMEOUT, a break resets, four stalled edges fire.
    for (int i = 0; i < 3; i++) cycle("wd_a", 4'b1000, 32'h0, 32'h0, 1'b0, 6'b011111, 1'b0, 32'h0);
    check("wd after 3", 32'(bus.stall_timeout), 32'h0);
    cycle("wd_break", 4'b0000, 32'h0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle("wd_b", 4'b1000, 32'h0, 32'h0, 1'b0, 6'b011111, 1'b0, 32'h0);
    check("wd after 3b", 32'(bus.stall_timeout), 32'h0);
    cycle("wd_b4", 4'b1000, 32'h0, 32'h0, 1'b0, 6'b011111, 1'b0, 32'h0);
    check("wd after 4", 32'(bus.stall_timeout), 32'h1);
    cycle("wd_hold", 4'b0000, 32'h0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0);
    cycle("clr2", 4'b0000, 32'h0, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
    check("clr2 flag", 32'(bus.stall_timeout), 32'h0);

    // Wrap of flush_count from a forced all-ones value.
    force dut.r_flush_count = 16'hFFFF;
    #1;
    release dut.r_flush_count;
    m_flush_count = 16'hFFFF;
    cycle("wrap_exc", 4'b0000, 32'h8, 32'h0, 1'b0, 6'b000000, 1'b1, 32'h20);
    check("wrap flush_count", 32'(bus.flush_count), 32'h0);
    cycle("wrap_guard", 4'b0000, 32'h0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0);

    // Reset asserted mid-cycle while MEM requests a stall.
    bus.stallreq_from_mem = 1'b1;
    #2;
    check("pre_rst stall", 32'(bus.stall), 32'h1f);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst stall",         32'(bus.stall),         32'h0);
    check("mid_rst flush",         32'(bus.flush),         32'h0);
    check("mid_rst stall_cycles",  bus.stall_cycles,       32'h0);
    check("mid_rst flush_count",   32'(bus.flush_count),   32'h0);
    check("mid_rst stall_timeout", 32'(bus.stall_timeout), 32'h0);
    @(negedge clk);
    check("held_rst stall",        32'(bus.stall),         32'h0);
    check("held_rst stall_cycles", bus.stall_cycles,       32'h0);
    model_reset();
    rst = 1'b1;
    cycle("post_rst", 4'b1000, 32'h0, 32'h0, 1'b0, 6'b011111, 1'b0, 32'h0);
    check("post_rst stall_cycles", bus.stall_cycles, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
